// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR coefficient loader and its register bus master.
//   REG_AW         : register address width of the FIR parameter space
//   FIR_PARAM_BASE : first address of the FIR parameter space
//   load_state_e   : loader FSM states
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int REG_AW = 12;

    localparam logic [REG_AW-1:0] FIR_PARAM_BASE = 12'h000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_FIN   = 3'd4
    } load_state_e;

endpackage

// File: rtl/reg_bus_master.sv
// -----------------------------------------------------------------------------
// reg_bus_master
// Drives one register-bus access at a time using the reg_ready toggle
// handshake. The request stays high until the first cycle reg_ready=1 is
// seen, which is reported on ack; a new issue in that same cycle chains the
// next access (write followed by readback) without a gap.
// Ports:
//   clk_2, rst_n          clock and async active-low reset
//   issue, op_rd          start an access (op_rd=1 read, 0 write)
//   op_addr, op_wdata     address and write data of the issued access
//   ack                   access completes this cycle
//   rdata                 read data, valid while ack is high on a read
//   reg_*                 registered bus outputs and slave inputs
// -----------------------------------------------------------------------------
module reg_bus_master
    import fir_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = 32
) (
    input  logic          clk_2,
    input  logic          rst_n,
    input  logic          issue,
    input  logic          op_rd,
    input  logic [AW-1:0] op_addr,
    input  logic [DW-1:0] op_wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] reg_addr,
    output logic          reg_wr,
    output logic          reg_rd,
    output logic [DW-1:0] reg_writedata,
    input  logic          reg_ready,
    input  logic [DW-1:0] reg_readdata
);

    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    assign ack   = reg_ready && (wr_q || rd_q);
    assign rdata = reg_readdata;

    // A read keeps the previous write data so the loader can compare the
    // readback against the word it just wrote.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (ack) begin
            wr_d = 1'b0;
            rd_d = 1'b0;
        end
        if (issue) begin
            wr_d   = !op_rd;
            rd_d   = op_rd;
            addr_d = op_addr;
            if (!op_rd) begin
                wdata_d = op_wdata;
            end
        end
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign reg_addr      = addr_q;
    assign reg_wr        = wr_q;
    assign reg_rd        = rd_q;
    assign reg_writedata = wdata_q;

endmodule

// File: rtl/fir_param_loader.sv
// -----------------------------------------------------------------------------
// fir_param_loader
// Streams coefficient words from a valid/ready source into the FIR parameter
// space, one register write per word at base_addr+idx (wrapping modulo 2^AW),
// optionally reading each word back and flagging the first mismatch.
// Ports:
//   clk_2, rst_n                    clock and async active-low reset
//   start, base_addr, word_cnt,
//   verify                          load request, sampled in IDLE only
//   coef_valid, coef_ready,
//   coef_data                       coefficient source handshake
//   reg_addr, reg_wr, reg_rd,
//   reg_writedata, reg_ready,
//   reg_readdata                    register bus (toggle handshake)
//   busy, done, err, err_addr       load status; err/err_addr are sticky
// -----------------------------------------------------------------------------
module fir_param_loader
    import fir_pkg::*;
#(
    parameter int AW        = REG_AW,
    parameter int DW        = 32,
    parameter int VERIFY_EN = 1
) (
    input  logic          clk_2,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] word_cnt,
    input  logic          verify,
    input  logic          coef_valid,
    output logic          coef_ready,
    input  logic [DW-1:0] coef_data,
    output logic [AW-1:0] reg_addr,
    output logic          reg_wr,
    output logic          reg_rd,
    output logic [DW-1:0] reg_writedata,
    input  logic          reg_ready,
    input  logic [DW-1:0] reg_readdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] err_addr
);

    load_state_e   state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          verify_q, verify_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW-1:0] err_addr_q, err_addr_d;

    logic          issue;
    logic          op_rd;
    logic [AW-1:0] op_addr;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          finish_word;
    logic [AW-1:0] idx_inc;

    assign idx_inc = idx_q + AW'(1);

    reg_bus_master #(
        .AW (AW),
        .DW (DW)
    ) u_bus (
        .clk_2         (clk_2),
        .rst_n         (rst_n),
        .issue         (issue),
        .op_rd         (op_rd),
        .op_addr       (op_addr),
        .op_wdata      (coef_data),
        .ack           (ack),
        .rdata         (rdata),
        .reg_addr      (reg_addr),
        .reg_wr        (reg_wr),
        .reg_rd        (reg_rd),
        .reg_writedata (reg_writedata),
        .reg_ready     (reg_ready),
        .reg_readdata  (reg_readdata)
    );

    // done is registered so it appears the cycle after the final ack. An
    // empty load passes through FIN first, which puts its done pulse two
    // cycles after start.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        verify_d    = verify_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        err_addr_d  = err_addr_q;
        issue       = 1'b0;
        op_rd       = 1'b0;
        op_addr     = reg_addr;
        coef_ready  = 1'b0;
        finish_word = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    cnt_d      = word_cnt;
                    idx_d      = '0;
                    verify_d   = verify && (VERIFY_EN != 0);
                    err_d      = 1'b0;
                    err_addr_d = '0;
                    if (word_cnt == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                coef_ready = 1'b1;
                if (coef_valid) begin
                    issue   = 1'b1;
                    op_addr = base_q + idx_q;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (ack) begin
                    if (verify_q) begin
                        issue   = 1'b1;
                        op_rd   = 1'b1;
                        state_d = ST_READ;
                    end else begin
                        finish_word = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (ack) begin
                    if ((rdata != reg_writedata) && !err_q) begin
                        err_d      = 1'b1;
                        err_addr_d = reg_addr;
                    end
                    finish_word = 1'b1;
                end
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                done_d  = (cnt_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish_word) begin
            idx_d = idx_inc;
            if (idx_inc == cnt_q) begin
                state_d = ST_FIN;
                done_d  = 1'b1;
            end else begin
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            verify_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            verify_q   <= verify_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule
